// File: rtl/watch_ctrl_gen2_if.sv
// Button and display bundle for watch_ctrl_gen2.
//   master : drives the debounced button pulses / setValue level,
//            observes the display digits and status outputs.
//   slave  : the watch controller itself.
interface watch_ctrl_gen2_if #(
  parameter int NUM_ALARMS = 2
);
  localparam int SLOT_W = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;

  logic              modeNext;
  logic              setValue;
  logic              nextd;
  logic              upTime;
  logic              start_resume;
  logic              stop;
  logic              resetTime;
  logic [3:0]        dis3;
  logic [3:0]        dis2;
  logic [3:0]        dis1;
  logic [3:0]        dis0;
  logic [1:0]        curMode;
  logic [1:0]        setCursor;
  logic [SLOT_W-1:0] alarmSlot;
  logic              alarmBeep;

  modport master (
    output modeNext, setValue, nextd, upTime, start_resume, stop, resetTime,
    input  dis3, dis2, dis1, dis0, curMode, setCursor, alarmSlot, alarmBeep
  );

  modport slave (
    input  modeNext, setValue, nextd, upTime, start_resume, stop, resetTime,
    output dis3, dis2, dis1, dis0, curMode, setCursor, alarmSlot, alarmBeep
  );
endinterface

// File: rtl/watch_ctrl_gen2.sv
// Digital watch controller: BCD time of day, stopwatch, NUM_ALARMS alarm
// slots with a timed beep, and a 4-digit registered display.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : watch_ctrl_gen2_if.slave (buttons in; dis3..0, curMode,
//           setCursor, alarmSlot, alarmBeep out)
module watch_ctrl_gen2 #(
  parameter int TICKS_PER_SEC = 100,
  parameter int NUM_ALARMS    = 2,
  parameter int BEEP_SECS     = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  watch_ctrl_gen2_if.slave bus
);
  localparam int PW     = $clog2(TICKS_PER_SEC);
  localparam int SLOT_W = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);

  typedef enum logic [1:0] {M_WATCH = 2'd0, M_STOPWATCH = 2'd1, M_ALARM = 2'd2} mode_t;
  typedef enum logic [1:0] {SW_IDLE = 2'd0, SW_RUN = 2'd1, SW_PAUSE = 2'd2} sw_t;

  mode_t mode_reg, mode_next;
  sw_t   sw_reg, sw_next;

  logic [PW-1:0]     presc_reg, sw_presc_reg;
  logic [5:0][3:0]   tm_reg, tm_inc;       // [5]=h1 .. [0]=s0
  logic [3:0][3:0]   sw_reg_cnt, sw_inc;   // [3]=m1 .. [0]=s0
  logic [3:0][3:0]   buf_reg, buf_next;    // edit buffer, [3]=d3
  logic [1:0]        cursor_reg, cursor_next;
  logic              set_prev_reg, edit_reg;
  logic [SLOT_W-1:0] alarm_slot_reg;
  logic [7:0]        beep_reg;
  logic [15:0]       dis_reg, sel_slot;
  logic [15:0]       slot_val [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] slot_en, slot_hit;

  logic sec_tick, sw_tick, set_rise, set_fall, edit_start, watch_load;
  logic slot_wr, slot_dis, alarm_match, sw_ok, sw_clear;

  assign sec_tick   = (presc_reg == PRESC_MAX);
  assign set_rise   = bus.setValue & ~set_prev_reg;
  assign set_fall   = ~bus.setValue & set_prev_reg & edit_reg;
  assign edit_start = set_rise & (mode_reg != M_STOPWATCH);
  assign watch_load = set_fall & (mode_reg == M_WATCH);
  assign slot_wr    = set_fall & (mode_reg == M_ALARM);
  assign slot_dis   = (mode_reg == M_ALARM) & ~bus.setValue & bus.resetTime;
  assign sw_ok      = (mode_reg == M_STOPWATCH);
  assign sw_clear   = sw_ok & bus.resetTime & (sw_reg != SW_RUN);
  assign sw_tick    = (sw_reg == SW_RUN) & (sw_presc_reg == PRESC_MAX);

  // Time of day plus one second, 23:59:59 -> 00:00:00.
  always_comb begin
    tm_inc = tm_reg;
    if (tm_reg[0] != 4'd9) tm_inc[0] = tm_reg[0] + 4'd1;
    else begin
      tm_inc[0] = 4'd0;
      if (tm_reg[1] != 4'd5) tm_inc[1] = tm_reg[1] + 4'd1;
      else begin
        tm_inc[1] = 4'd0;
        if (tm_reg[2] != 4'd9) tm_inc[2] = tm_reg[2] + 4'd1;
        else begin
          tm_inc[2] = 4'd0;
          if (tm_reg[3] != 4'd5) tm_inc[3] = tm_reg[3] + 4'd1;
          else begin
            tm_inc[3] = 4'd0;
            if (tm_reg[5] == 4'd2 && tm_reg[4] == 4'd3) begin
              tm_inc[5] = 4'd0;
              tm_inc[4] = 4'd0;
            end else if (tm_reg[4] == 4'd9) begin
              tm_inc[4] = 4'd0;
              tm_inc[5] = tm_reg[5] + 4'd1;
            end else begin
              tm_inc[4] = tm_reg[4] + 4'd1;
            end
          end
        end
      end
    end
  end

  // Stopwatch count plus one second, 59:59 -> 00:00.
  always_comb begin
    sw_inc = sw_reg_cnt;
    if (sw_reg_cnt[0] != 4'd9) sw_inc[0] = sw_reg_cnt[0] + 4'd1;
    else begin
      sw_inc[0] = 4'd0;
      if (sw_reg_cnt[1] != 4'd5) sw_inc[1] = sw_reg_cnt[1] + 4'd1;
      else begin
        sw_inc[1] = 4'd0;
        if (sw_reg_cnt[2] != 4'd9) sw_inc[2] = sw_reg_cnt[2] + 4'd1;
        else begin
          sw_inc[2] = 4'd0;
          sw_inc[3] = (sw_reg_cnt[3] == 4'd5) ? 4'd0 : sw_reg_cnt[3] + 4'd1;
        end
      end
    end
  end

  // Alarm slots: each slot owns its registers; the match compares against
  // the time that this sec_tick is about to produce.
  for (genvar gi = 0; gi < NUM_ALARMS; gi++) begin : g_slot
    logic [15:0] val_q;
    logic        en_q;
    logic        sel;
    assign sel = (alarm_slot_reg == SLOT_W'(gi));
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        val_q <= 16'h0000;
        en_q  <= 1'b0;
      end else if (slot_wr && sel) begin
        val_q <= buf_reg;
        en_q  <= 1'b1;
      end else if (slot_dis && sel) begin
        en_q  <= 1'b0;
      end
    end
    assign slot_val[gi] = val_q;
    assign slot_en[gi]  = en_q;
    assign slot_hit[gi] = en_q && (val_q == {tm_inc[5], tm_inc[4], tm_inc[3], tm_inc[2]});
  end

  always_comb begin
    sel_slot = 16'h0000;
    for (int i = 0; i < NUM_ALARMS; i++)
      if (alarm_slot_reg == SLOT_W'(i)) sel_slot = slot_val[i];
  end

  // A time load from the editor overrides the tick, so no match then.
  assign alarm_match = sec_tick && !watch_load && (tm_inc[1] == 4'd0) &&
                       (tm_inc[0] == 4'd0) && (|slot_hit);

  // Edit buffer and cursor; the increment uses the old cursor even when
  // nextd moves it in the same cycle.
  always_comb begin
    buf_next    = buf_reg;
    cursor_next = cursor_reg;
    if (edit_start) begin
      buf_next    = (mode_reg == M_ALARM) ? sel_slot : {tm_reg[5], tm_reg[4], tm_reg[3], tm_reg[2]};
      cursor_next = 2'd3;
    end else if (edit_reg && bus.setValue) begin
      if (bus.upTime) begin
        case (cursor_reg)
          2'd3: begin
            buf_next[3] = (buf_reg[3] >= 4'd2) ? 4'd0 : buf_reg[3] + 4'd1;
            if (buf_next[3] == 4'd2 && buf_reg[2] > 4'd3) buf_next[2] = 4'd3;
          end
          2'd2: begin
            if (buf_reg[2] >= ((buf_reg[3] == 4'd2) ? 4'd3 : 4'd9)) buf_next[2] = 4'd0;
            else buf_next[2] = buf_reg[2] + 4'd1;
          end
          2'd1: buf_next[1] = (buf_reg[1] >= 4'd5) ? 4'd0 : buf_reg[1] + 4'd1;
          default: buf_next[0] = (buf_reg[0] >= 4'd9) ? 4'd0 : buf_reg[0] + 4'd1;
        endcase
      end
      if (bus.nextd) cursor_next = cursor_reg - 2'd1;   // 0 wraps to 3
    end
  end

  always_comb begin
    mode_next = mode_reg;
    if (bus.modeNext && !bus.setValue) begin
      case (mode_reg)
        M_WATCH:     mode_next = M_STOPWATCH;
        M_STOPWATCH: mode_next = M_ALARM;
        default:     mode_next = M_WATCH;
      endcase
    end
  end

  always_comb begin
    sw_next = sw_reg;
    case (sw_reg)
      SW_IDLE:  if (sw_ok && bus.start_resume) sw_next = SW_RUN;
      SW_RUN:   if (sw_ok && bus.stop) sw_next = SW_PAUSE;
      SW_PAUSE: begin
        if (sw_ok && bus.start_resume) sw_next = SW_RUN;
        else if (sw_ok && bus.resetTime) sw_next = SW_IDLE;
      end
      default:  sw_next = SW_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_reg       <= M_WATCH;
      sw_reg         <= SW_IDLE;
      presc_reg      <= '0;
      sw_presc_reg   <= '0;
      tm_reg         <= '0;
      sw_reg_cnt     <= '0;
      buf_reg        <= '0;
      cursor_reg     <= 2'd3;
      set_prev_reg   <= 1'b0;
      edit_reg       <= 1'b0;
      alarm_slot_reg <= '0;
      beep_reg       <= 8'd0;
      dis_reg        <= 16'h0000;
    end else begin
      mode_reg     <= mode_next;
      sw_reg       <= sw_next;
      buf_reg      <= buf_next;
      cursor_reg   <= cursor_next;
      set_prev_reg <= bus.setValue;
      if (edit_start) edit_reg <= 1'b1;
      else if (!bus.setValue) edit_reg <= 1'b0;

      if (watch_load) begin
        tm_reg    <= {buf_reg[3], buf_reg[2], buf_reg[1], buf_reg[0], 4'd0, 4'd0};
        presc_reg <= '0;
      end else begin
        if (sec_tick) tm_reg <= tm_inc;
        presc_reg <= sec_tick ? '0 : presc_reg + PW'(1);
      end

      // Idle keeps the stopwatch prescaler cleared so a start begins at 0;
      // pause simply holds it.
      if (sw_reg == SW_IDLE) sw_presc_reg <= '0;
      else if (sw_reg == SW_RUN) sw_presc_reg <= sw_tick ? '0 : sw_presc_reg + PW'(1);

      if (sw_clear) sw_reg_cnt <= '0;
      else if (sw_tick) sw_reg_cnt <= sw_inc;

      if (mode_reg == M_ALARM && !bus.setValue && bus.nextd)
        alarm_slot_reg <= (alarm_slot_reg == SLOT_W'(NUM_ALARMS - 1)) ? '0 : alarm_slot_reg + SLOT_W'(1);

      if (bus.stop) beep_reg <= 8'd0;
      else if (alarm_match) beep_reg <= 8'(BEEP_SECS);
      else if (sec_tick && beep_reg != 8'd0) beep_reg <= beep_reg - 8'd1;

      case (mode_reg)
        M_WATCH:     dis_reg <= edit_reg ? buf_reg : {tm_reg[5], tm_reg[4], tm_reg[3], tm_reg[2]};
        M_STOPWATCH: dis_reg <= sw_reg_cnt;
        M_ALARM:     dis_reg <= edit_reg ? buf_reg : sel_slot;
        default:     dis_reg <= 16'h0000;
      endcase
    end
  end

  assign bus.dis3      = dis_reg[15:12];
  assign bus.dis2      = dis_reg[11:8];
  assign bus.dis1      = dis_reg[7:4];
  assign bus.dis0      = dis_reg[3:0];
  assign bus.curMode   = mode_reg;
  assign bus.setCursor = cursor_reg;
  assign bus.alarmSlot = alarm_slot_reg;
  assign bus.alarmBeep = (beep_reg != 8'd0);
endmodule

// File: doc/watch_ctrl_gen2.md
WATCH_CTRL_GEN2 -- requirements
Module: watch_ctrl_gen2

Interface
REQ-001 SHALL have parameter TICKS_PER_SEC, default 100; clk cycles per second, minimum 2.
REQ-002 SHALL have parameter NUM_ALARMS, default 2; number of alarm slots, range 1..8.
REQ-003 SHALL have parameter BEEP_SECS, default 10; alarm beep duration in seconds, range 1..255.
REQ-004 SHALL have these ports, all inputs synchronous to clk; button inputs are debounced single-cycle pulses:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- modeNext  in  1  pulse; advance display mode.
- setValue  in  1  level; edit mode active while 1.
- nextd  in  1  pulse; advance edit cursor (set) or alarm slot (ALARM, not set).
- upTime  in  1  pulse; increment digit at cursor.
- start_resume  in  1  pulse; stopwatch start/resume.
- stop  in  1  pulse; stopwatch pause; silences beep in any mode.
- resetTime  in  1  pulse; stopwatch clear (STOPWATCH) or slot disable (ALARM).
- dis3..dis0  out  4 each  BCD display digits, left to right.
- curMode  out  2  0=WATCH, 1=STOPWATCH, 2=ALARM.
- setCursor  out  2  edit digit index, 3..0.
- alarmSlot  out  clog2(NUM_ALARMS), min 1  selected slot.
- alarmBeep  out  1  alarm sounding.

Function
REQ-005 Prescaler SHALL count 0..TICKS_PER_SEC-1, wrap to 0, and assert internal sec_tick in the wrap cycle.
REQ-006 Time SHALL be BCD hh:mm:ss, advanced on sec_tick; 23:59:59 SHALL wrap to 00:00:00; it SHALL keep running in every mode and during edit.
REQ-007 Mode FSM SHALL be WATCH->STOPWATCH->ALARM->WATCH on modeNext; modeNext SHALL be ignored while setValue=1.
REQ-008 setValue rising edge in WATCH SHALL load the edit buffer from current hh:mm; in ALARM, from the selected slot; setCursor SHALL become 3.
REQ-009 setValue SHALL be ignored in STOPWATCH.
REQ-010 While editing, upTime SHALL increment the cursor digit with wrap: d3 0..2; d2 0..9, or 0..3 when d3=2; d1 0..5; d0 0..9.
REQ-011 An upTime that makes d3=2 while d2>3 SHALL clamp d2 to 3 in the same cycle.
REQ-012 nextd while editing SHALL move the cursor 3->2->1->0->3.
REQ-013 When upTime and nextd coincide, the increment SHALL apply at the old cursor and the cursor SHALL then advance.
REQ-014 setValue falling edge in WATCH SHALL load hh:mm from the buffer, clear ss and clear the prescaler.
REQ-015 setValue falling edge in ALARM SHALL write the buffer to the selected slot and set that slot's enable.
REQ-016 Stopwatch FSM SHALL have states SW_IDLE, SW_RUN and SW_PAUSE; its buttons act only when curMode=STOPWATCH.
REQ-017 start_resume SHALL move SW_IDLE or SW_PAUSE to SW_RUN; leaving SW_IDLE SHALL clear the stopwatch prescaler.
REQ-018 stop SHALL move SW_RUN to SW_PAUSE.
REQ-019 resetTime SHALL move SW_PAUSE or SW_IDLE to SW_IDLE and clear the count; resetTime in SW_RUN SHALL be ignored.
REQ-020 The stopwatch SHALL run in the background in other modes, with its own TICKS_PER_SEC prescaler held in SW_PAUSE.
REQ-021 The stopwatch count SHALL be BCD mm:ss, 00:00..59:59, wrapping to 00:00.
REQ-022 In ALARM mode with setValue=0, nextd SHALL advance alarmSlot modulo NUM_ALARMS, and resetTime SHALL clear the selected slot's enable.
REQ-023 On a sec_tick producing ss=00 where hh:mm equals any enabled slot, the beep counter SHALL load BEEP_SECS.
REQ-024 alarmBeep SHALL be 1 while the beep counter is >0; the counter SHALL decrement on each sec_tick.
REQ-025 stop in any mode SHALL clear the beep counter; stop SHALL win over a match in the same cycle.
REQ-026 A match while beeping SHALL reload BEEP_SECS.
REQ-027 Display SHALL be registered with 1-cycle latency:
- WATCH: hh:mm, or the buffer when editing.
- STOPWATCH: mm:ss.
- ALARM: selected slot, or the buffer when editing.

Reset
REQ-028 rst_n=0 SHALL immediately clear: time 00:00:00, both prescalers, mode WATCH, SW_IDLE, count 00:00, all slots 00:00 disabled, alarmSlot 0, cursor 3, beep counter 0, dis* 0, alarmBeep 0.
REQ-029 Reset mid-edit or mid-beep SHALL discard the buffer and the beep without any write.

Verification (TICKS_PER_SEC=4, NUM_ALARMS=2, BEEP_SECS=3)
REQ-030 Time 23:59:59, one sec_tick -> 00:00:00; dis=0,0,0,0 one cycle later.
REQ-031 WATCH, setValue=1, upTime x2 at cursor 3 with buffer 09:xx -> buffer 23:xx (d2 clamped to 3); release -> time 23:xx:00.
REQ-032 STOPWATCH: start, 8 cycles, stop, resetTime -> dis shows 00:02 while paused, then 00:00; resetTime during SW_RUN is ignored.
REQ-033 Slot1 set to 00:01, time reaches 00:01:00 -> alarmBeep high for 12 cycles; stop in cycle 5 -> low next cycle.
REQ-034 ALARM mode, nextd then resetTime -> alarmSlot=1 and slot1 disabled; no beep at a slot1 match.
REQ-035 rst_n low mid-edit in ALARM -> all outputs 0, curMode=0, slots unchanged from reset values.
